// File: rtl/io_uart_tx_pkg.sv
// rtl/io_uart_tx_pkg.sv - shared constants and types for the IO-side UART transmitter
// Purpose: register offsets (addr[3:2]), TX state encoding, STATUS/CTRL bit positions.
// Ports: none (package).
package io_uart_tx_pkg;

  localparam logic [1:0] REG_TXDATA  = 2'd0;
  localparam logic [1:0] REG_STATUS  = 2'd1;
  localparam logic [1:0] REG_BAUDDIV = 2'd2;
  localparam logic [1:0] REG_CTRL    = 2'd3;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } tx_state_t;

  localparam int STAT_CNT_LSB = 0;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_FULL    = 3;
  localparam int STAT_BUSY    = 4;
  localparam int STAT_OVF     = 5;

  localparam int CTRL_IRQ_EN  = 0;
  localparam int CTRL_PAR_ODD = 1;

endpackage

// File: rtl/io_uart_tx_if.sv
// rtl/io_uart_tx_if.sv - IO chip-select bus between the decoder and the UART transmitter
// Purpose: groups the register-access signals.
// Signals: ce (chip select), we (write enable), addr (byte address),
//          wtData (store data), rdData (combinational load data).
interface io_uart_tx_if;
  logic        ce;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wtData;
  logic [31:0] rdData;

  modport master (output ce, we, addr, wtData, input rdData);
  modport slave  (input ce, we, addr, wtData, output rdData);
endinterface

// File: rtl/io_uart_tx_fifo.sv
// rtl/io_uart_tx_fifo.sv - byte FIFO feeding the UART transmitter
// Purpose: synchronous FIFO; a push while full is accepted only when a pop
//          happens on the same edge, otherwise it is dropped.
// Ports: clk, rst (async active-low), push/din, pop/dout (head, combinational),
//        full, empty, count ($clog2(DEPTH)+1 bits).
module uart_tx_fifo #(
  parameter int DEPTH = 8,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [7:0]    din,
  input  logic          pop,
  output logic [7:0]    dout,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign pop_ok  = pop && !empty;
  // The slot freed by a same-edge pop makes room for the incoming byte.
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/io_uart_tx.sv
// rtl/io_uart_tx.sv - memory-mapped 8-N-1 UART transmitter with FIFO and level interrupt
// Purpose: register file (TXDATA/STATUS/BAUDDIV/CTRL), baud counter and TX FSM.
// Ports: clk, rst (async active-low), bus (io_uart_tx_if.slave: ce, we, addr,
//        wtData, rdData), txd (serial out, idle high), txIrq (drained interrupt).
// Optional feature macro: UART_TX_PARITY_EN (parity bit, CTRL bit1 = parOdd).
module io_uart_tx
  import io_uart_tx_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int DEFAULT_DIV = 433
) (
  input  logic        clk,
  input  logic        rst,
  io_uart_tx_if.slave bus,
  output logic        txd,
  output logic        txIrq
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [1:0]    reg_sel;
  logic          wr;
  logic          fifo_push;
  logic          fifo_pop;
  logic [7:0]    fifo_dout;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  logic [15:0]   baud_div;
  logic          irq_en;
  logic          ovf;
  tx_state_t     state;
  logic [15:0]   baud_cnt;
  logic [7:0]    shreg;
  logic [2:0]    bit_idx;
  logic          bit_end;
  logic          busy;
  logic [31:0]   status_word;
  logic [31:0]   ctrl_word;
  logic [31:0]   rd_data;
`ifdef UART_TX_PARITY_EN
  logic          par_odd;
  logic          par_bit;
`endif

  assign reg_sel   = bus.addr[3:2];
  assign wr        = bus.ce && bus.we;
  assign fifo_push = wr && (reg_sel == REG_TXDATA);
  assign bit_end   = (baud_cnt == '0);
  assign busy      = (state != ST_IDLE);
  // A byte leaves the FIFO when the line is idle, or at the end of a stop bit
  // so the next start bit follows with no idle gap.
  assign fifo_pop  = !fifo_empty &&
                     ((state == ST_IDLE) || ((state == ST_STOP) && bit_end));
  assign txIrq     = irq_en && fifo_empty && !busy;

  wire unused_bits = &{1'b0, bus.addr[31:4], bus.addr[1:0], bus.wtData[31:16],
                       (fifo_count >> 2)};

  uart_tx_fifo #(.DEPTH(DEPTH), .CW(CW)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (fifo_push),
    .din   (bus.wtData[7:0]),
    .pop   (fifo_pop),
    .dout  (fifo_dout),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // Register file
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      baud_div <= 16'(DEFAULT_DIV);
      irq_en   <= 1'b0;
      ovf      <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_odd  <= 1'b0;
`endif
    end else begin
      if (wr && (reg_sel == REG_BAUDDIV)) baud_div <= bus.wtData[15:0];
      if (wr && (reg_sel == REG_CTRL)) begin
        irq_en  <= bus.wtData[CTRL_IRQ_EN];
`ifdef UART_TX_PARITY_EN
        par_odd <= bus.wtData[CTRL_PAR_ODD];
`endif
      end
      if (fifo_push && fifo_full && !fifo_pop) ovf <= 1'b1;
      else if (wr && (reg_sel == REG_STATUS)) ovf <= 1'b0;
    end
  end

  // TX FSM with baud counter; txd is registered and changes only at bit starts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      txd      <= 1'b1;
      baud_cnt <= '0;
      shreg    <= '0;
      bit_idx  <= '0;
`ifdef UART_TX_PARITY_EN
      par_bit  <= 1'b0;
`endif
    end else begin
      // BAUDDIV is sampled only here, so a mid-frame write lands at the next bit.
      if (state != ST_IDLE) baud_cnt <= bit_end ? baud_div : baud_cnt - 16'd1;
      case (state)
        ST_IDLE: begin
          if (fifo_pop) begin
            state    <= ST_START;
            txd      <= 1'b0;
            baud_cnt <= baud_div;
            shreg    <= fifo_dout;
`ifdef UART_TX_PARITY_EN
            par_bit  <= ^fifo_dout;
`endif
          end
        end
        ST_START: begin
          if (bit_end) begin
            state   <= ST_DATA;
            txd     <= shreg[0];
            shreg   <= {1'b0, shreg[7:1]};
            bit_idx <= 3'd0;
          end
        end
        ST_DATA: begin
          if (bit_end) begin
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= ST_PARITY;
              txd   <= par_bit ^ par_odd;
`else
              state <= ST_STOP;
              txd   <= 1'b1;
`endif
            end else begin
              txd     <= shreg[0];
              shreg   <= {1'b0, shreg[7:1]};
              bit_idx <= bit_idx + 3'd1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: begin
          if (bit_end) begin
            state <= ST_STOP;
            txd   <= 1'b1;
          end
        end
`endif
        ST_STOP: begin
          if (bit_end) begin
            if (fifo_pop) begin
              state   <= ST_START;
              txd     <= 1'b0;
              shreg   <= fifo_dout;
`ifdef UART_TX_PARITY_EN
              par_bit <= ^fifo_dout;
`endif
            end else begin
              state <= ST_IDLE;
              txd   <= 1'b1;
            end
          end
        end
        default: begin
          state <= ST_IDLE;
          txd   <= 1'b1;
        end
      endcase
    end
  end

  // Read path
  always_comb begin
    status_word = '0;
    status_word[STAT_CNT_LSB +: 2] = fifo_count[1:0];
    status_word[STAT_EMPTY]        = fifo_empty;
    status_word[STAT_FULL]         = fifo_full;
    status_word[STAT_BUSY]         = busy;
    status_word[STAT_OVF]          = ovf;
  end

  always_comb begin
    ctrl_word = '0;
    ctrl_word[CTRL_IRQ_EN] = irq_en;
`ifdef UART_TX_PARITY_EN
    ctrl_word[CTRL_PAR_ODD] = par_odd;
`endif
  end

  always_comb begin
    rd_data = '0;
    if (bus.ce && !bus.we) begin
      case (reg_sel)
        REG_STATUS:  rd_data = status_word;
        REG_BAUDDIV: rd_data = {16'h0, baud_div};
        REG_CTRL:    rd_data = ctrl_word;
        default:     rd_data = '0;
      endcase
    end
  end

  assign bus.rdData = rd_data;

endmodule

// File: tb/tb_io_uart_tx.sv
// tb/tb_io_uart_tx.sv - self-checking bench for io_uart_tx
module tb_io_uart_tx;
  import io_uart_tx_pkg::*;

  logic clk;
  logic rst;
  logic txd;
  logic txIrq;
  int   errors;
  int   checks;
  int   dur_tab [11];
  logic cap_q [$];

  io_uart_tx_if bus ();

  io_uart_tx #(.DEPTH(8), .DEFAULT_DIV(433)) dut (
    .clk   (clk),
    .rst   (rst),
    .bus   (bus.slave),
    .txd   (txd),
    .txIrq (txIrq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  typedef struct {
    logic        ce;
    logic        we;
    logic [1:0]  a;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.ce = 1'b1; bus.we = 1'b1; bus.addr = {28'h0, a, 2'b00}; bus.wtData = d;
    @(posedge clk);
    #1;
    bus.ce = 1'b0; bus.we = 1'b0;
  endtask

  task automatic rd(input logic [1:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.ce = 1'b1; bus.we = 1'b0; bus.addr = {28'h0, a, 2'b00};
    #1;
    d = bus.rdData;
    bus.ce = 1'b0;
  endtask

  task automatic capture(input int n);
    cap_q.delete();
    repeat (n) begin
      @(negedge clk);
      cap_q.push_back(txd);
    end
  endtask

  task automatic set_dur(input int d);
    for (int i = 0; i < 11; i++) dur_tab[i] = d;
  endtask

  task automatic check_frame(input string name, input int start, input logic [7:0] data,
                             input int nb, input logic par, output int next_idx);
    logic [10:0] fr;
    int p;
    int bad;
    fr = (nb == 11) ? {1'b1, par, data, 1'b0} : {1'b0, 1'b1, data, 1'b0};
    p = start;
    for (int b = 0; b < nb; b++) begin
      bad = 0;
      for (int j = 0; j < dur_tab[b]; j++)
        if ((p + j) >= cap_q.size() || cap_q[p + j] !== fr[b]) bad++;
      checks++;
      if (bad != 0) begin
        errors++;
        $display("FAIL %s bit%0d: %0d of %0d samples wrong, required txd=%0b", name, b, bad, dur_tab[b], fr[b]);
      end
      p += dur_tab[b];
    end
    next_idx = p;
  endtask

  task automatic check_idle(input string name, input int from, input int to);
    int bad;
    bad = 0;
    for (int i = from; i < to; i++)
      if (i >= cap_q.size() || cap_q[i] !== 1'b1) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s: %0d low/missing samples in idle window, required all 1", name, bad);
    end
  endtask

  initial begin
    logic [31:0] r;
    int nx;
    errors = 0;
    checks = 0;
    bus.ce = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.wtData = '0;
    rst = 1'b0;

    vecs[0]  = '{1'b1, 1'b0, REG_STATUS,  32'h0,        32'h4,    1'b0};
    vecs[1]  = '{1'b1, 1'b0, REG_BAUDDIV, 32'h0,        32'd433,  1'b0};
    vecs[2]  = '{1'b1, 1'b0, REG_CTRL,    32'h0,        32'h0,    1'b0};
    vecs[3]  = '{1'b1, 1'b0, REG_TXDATA,  32'h0,        32'h0,    1'b0};
    vecs[4]  = '{1'b0, 1'b0, REG_STATUS,  32'h0,        32'h0,    1'b0};
    vecs[5]  = '{1'b0, 1'b1, REG_BAUDDIV, 32'h5,        32'h0,    1'b0};
    vecs[6]  = '{1'b1, 1'b0, REG_BAUDDIV, 32'h0,        32'd433,  1'b0};
    vecs[7]  = '{1'b1, 1'b1, REG_BAUDDIV, 32'hABCD1234, 32'h0,    1'b0};
    vecs[8]  = '{1'b1, 1'b0, REG_BAUDDIV, 32'h0,        32'h1234, 1'b0};
    vecs[9]  = '{1'b1, 1'b1, REG_CTRL,    32'hFFFFFFFE, 32'h0,    1'b0};
`ifdef UART_TX_PARITY_EN
    vecs[10] = '{1'b1, 1'b0, REG_CTRL,    32'h0,        32'h2,    1'b0};
`else
    vecs[10] = '{1'b1, 1'b0, REG_CTRL,    32'h0,        32'h0,    1'b0};
`endif
    vecs[11] = '{1'b1, 1'b1, REG_CTRL,    32'h1,        32'h0,    1'b0};
    vecs[12] = '{1'b1, 1'b0, REG_CTRL,    32'h0,        32'h1,    1'b1};
    vecs[13] = '{1'b1, 1'b1, REG_CTRL,    32'h0,        32'h0,    1'b1};
    vecs[14] = '{1'b1, 1'b0, REG_STATUS,  32'h0,        32'h4,    1'b0};
    vecs[15] = '{1'b1, 1'b1, REG_STATUS,  32'hFFFFFFFF, 32'h0,    1'b0};
    vecs[16] = '{1'b1, 1'b0, REG_STATUS,  32'h0,        32'h4,    1'b0};

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_txd", {31'h0, txd}, 32'h1);
    check("reset_irq", {31'h0, txIrq}, 32'h0);
    rst = 1'b1;

    // Register access table; addr carries junk outside [3:2]
    for (int i = 0; i < 17; i++) begin
      @(negedge clk);
      bus.ce = vecs[i].ce; bus.we = vecs[i].we;
      bus.addr = {28'h5A5A5A5, vecs[i].a, 2'b11}; bus.wtData = vecs[i].wd;
      #1;
      check($sformatf("vec%0d_rd", i), bus.rdData, vecs[i].exp_rd);
      check($sformatf("vec%0d_irq", i), {31'h0, txIrq}, {31'h0, vecs[i].exp_irq});
      @(posedge clk);
      #1;
      bus.ce = 1'b0; bus.we = 1'b0;
    end

    // Single frame 0x55, BAUDDIV=3
    wr(REG_BAUDDIV, 32'd3);
    wr(REG_TXDATA, 32'h55);
    capture(45);
    set_dur(4);
    check_idle("f55_pre", 0, 1);
    check_frame("f55", 1, 8'h55, 10, 1'b0, nx);
    check_idle("f55_post", 41, 45);
    rd(REG_STATUS, r);
    check("f55_status_drained", r, 32'h4);
    check("f55_irq_disabled", {31'h0, txIrq}, 32'h0);
    wr(REG_CTRL, 32'h1);
    check("f55_irq_raised", {31'h0, txIrq}, 32'h1);
    wr(REG_CTRL, 32'h0);

    // Nine back-to-back bytes at BAUDDIV=0, tenth overflows
    wr(REG_BAUDDIV, 32'd0);
    wr(REG_TXDATA, 32'hA0);
    fork
      capture(110);
      begin
        for (int i = 1; i < 9; i++) wr(REG_TXDATA, 32'hA0 + i);
        wr(REG_TXDATA, 32'hFF);
        rd(REG_STATUS, r);
        check("b2b_status_full_ovf", r, 32'h38);
        wr(REG_STATUS, 32'h0);
        rd(REG_STATUS, r);
        check("b2b_status_ovf_clr", r, 32'h13);
      end
    join
    set_dur(1);
    check_idle("b2b_pre", 0, 1);
    nx = 1;
    for (int f = 0; f < 9; f++)
      check_frame($sformatf("b2b_f%0d", f), nx, 8'(8'hA0 + f), 10, 1'b0, nx);
    check_idle("b2b_post", 91, 110);

    // BAUDDIV 1 -> 7 during DATA bit 1
    wr(REG_BAUDDIV, 32'd1);
    wr(REG_TXDATA, 32'h55);
    fork
      capture(75);
      begin
        repeat (5) @(posedge clk);
        wr(REG_BAUDDIV, 32'd7);
      end
    join
    set_dur(8);
    dur_tab[0] = 2; dur_tab[1] = 2; dur_tab[2] = 2;
    check_frame("divchg", 1, 8'h55, 10, 1'b0, nx);
    check_idle("divchg_post", 71, 75);

    // Asynchronous reset during DATA bit 3
    wr(REG_BAUDDIV, 32'd3);
    wr(REG_TXDATA, 32'h00);
    wr(REG_TXDATA, 32'h00);
    repeat (18) @(posedge clk);
    #2;
    check("rst_pre_txd", {31'h0, txd}, 32'h0);
    rst = 1'b0;
    #1;
    check("rst_async_txd", {31'h0, txd}, 32'h1);
    bus.ce = 1'b1; bus.we = 1'b0; bus.addr = {28'h0, REG_STATUS, 2'b00};
    #1;
    check("rst_fifo_flushed", bus.rdData, 32'h4);
    bus.ce = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    capture(40);
    check_idle("rst_no_frame", 0, 40);
    rd(REG_BAUDDIV, r);
    check("rst_bauddiv", r, 32'd433);

`ifdef UART_TX_PARITY_EN
    // 0x07 has three ones: even parity bit 1, odd parity bit 0
    wr(REG_BAUDDIV, 32'd1);
    wr(REG_CTRL, 32'h1);
    wr(REG_TXDATA, 32'h07);
    capture(26);
    set_dur(2);
    check_frame("par_even", 1, 8'h07, 11, 1'b1, nx);
    check_idle("par_even_post", 23, 26);
    wr(REG_CTRL, 32'h3);
    wr(REG_TXDATA, 32'h07);
    capture(26);
    check_frame("par_odd", 1, 8'h07, 11, 1'b0, nx);
    check_idle("par_odd_post", 23, 26);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
